// File: rtl/palette_writer.sv
// rtl/palette_writer.sv - R,G,B byte-stream loader for the 256-entry palette RAM write port.
// Optional PALETTE_VBLANK_WR_EN: hold each commit until vblank so the palette never changes mid-frame.
module palette_writer #(
  parameter int IDX_W  = 8,
  parameter int COMP_W = 8
) (
  input  logic                clk_pix,
  input  logic                rst_n,
  input  logic                addr_set,
  input  logic [IDX_W-1:0]    addr_in,
  input  logic                data_valid,
  input  logic [COMP_W-1:0]   data,
  output logic                data_ready,
  input  logic                vblank,
  output logic                wr_en,
  output logic [IDX_W-1:0]    wr_addr,
  output logic [3*COMP_W-1:0] wr_rgb,
  output logic [IDX_W-1:0]    index
);

  typedef enum logic [1:0] {S_R, S_G, S_B, S_COMMIT} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [COMP_W-1:0]   r_q, r_d, g_q, g_d;
  logic [IDX_W-1:0]    wr_addr_q, wr_addr_d;
  logic [3*COMP_W-1:0] wr_rgb_q, wr_rgb_d;
  logic                commit_ok;
  logic                hs;

`ifdef PALETTE_VBLANK_WR_EN
  assign commit_ok = vblank;
`else
  logic vblank_unused;
  assign vblank_unused = vblank;
  assign commit_ok     = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    r_d        = r_q;
    g_d        = g_q;
    wr_addr_d  = wr_addr_q;
    wr_rgb_d   = wr_rgb_q;
    data_ready = (state_q != S_COMMIT) && !addr_set;
    wr_en      = (state_q == S_COMMIT) && commit_ok;
    hs         = data_valid && data_ready;

    if (state_q == S_COMMIT) begin
      // addr_set is deliberately ignored here; the host waits for data_ready first.
      if (commit_ok) begin
        index_d = index_q + IDX_W'(1);
        state_d = S_R;
      end
    end else if (addr_set) begin
      index_d = addr_in;
      state_d = S_R;
    end else if (hs) begin
      case (state_q)
        S_R: begin
          r_d     = data;
          state_d = S_G;
        end
        S_G: begin
          g_d     = data;
          state_d = S_B;
        end
        default: begin
          wr_rgb_d  = {r_q, g_q, data};
          wr_addr_d = index_q;
          state_d   = S_COMMIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_R;
      index_q   <= '0;
      r_q       <= '0;
      g_q       <= '0;
      wr_addr_q <= '0;
      wr_rgb_q  <= '0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      r_q       <= r_d;
      g_q       <= g_d;
      wr_addr_q <= wr_addr_d;
      wr_rgb_q  <= wr_rgb_d;
    end
  end

  assign wr_addr = wr_addr_q;
  assign wr_rgb  = wr_rgb_q;
  assign index   = index_q;

endmodule

// File: tb/tb_palette_writer.sv
// tb/tb_palette_writer.sv - directed and randomized bench for palette_writer against a byte-list model.
module tb_palette_writer;

  logic        clk_pix = 1'b0;
  logic        rst_n;
  logic        addr_set;
  logic [7:0]  addr_in;
  logic        data_valid;
  logic [7:0]  data;
  logic        data_ready;
  logic        vblank;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [23:0] wr_rgb;
  logic [7:0]  index;

  palette_writer dut (
    .clk_pix    (clk_pix),
    .rst_n      (rst_n),
    .addr_set   (addr_set),
    .addr_in    (addr_in),
    .data_valid (data_valid),
    .data       (data),
    .data_ready (data_ready),
    .vblank     (vblank),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_rgb     (wr_rgb),
    .index      (index)
  );

  always #5 clk_pix = ~clk_pix;

  int vectors = 0;
  int miscompares = 0;

  // Model: bytes gathered so far, whether a finished entry awaits its write, and the RAM-port view.
  logic [7:0]  got[$];
  bit          pend;
  int          m_idx;
  logic [7:0]  m_addr;
  logic [23:0] m_rgb;
  int          dut_wr;
  int          ready_low;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    got.delete();
    pend   = 1'b0;
    m_idx  = 0;
    m_addr = 8'h00;
    m_rgb  = 24'h0;
  endtask

  // One clock: drive inputs after the falling edge, check mid-cycle, advance the model at the rising edge.
  task automatic cyc(input logic as, input logic [7:0] ai, input logic dv, input logic [7:0] d,
                     input logic vb, output bit accepted);
    bit exp_ready, ok, exp_wr;
    addr_set = as; addr_in = ai; data_valid = dv; data = d; vblank = vb;
`ifdef PALETTE_VBLANK_WR_EN
    ok = vb;
`else
    ok = 1'b1;
`endif
    exp_ready = !pend && !as;
    exp_wr    = pend && ok;
    #1;
    chk("data_ready", 32'(data_ready), 32'(exp_ready));
    chk("wr_en", 32'(wr_en), 32'(exp_wr));
    chk("index", 32'(index), 32'(m_idx));
    chk("wr_addr", 32'(wr_addr), 32'(m_addr));
    chk("wr_rgb", 32'(wr_rgb), 32'(m_rgb));
    if (wr_en) dut_wr++;
    if (!data_ready) ready_low++;
    accepted = dv && exp_ready;
    @(posedge clk_pix);
    if (pend) begin
      if (ok) begin
        m_idx = (m_idx + 1) % 256;
        pend  = 1'b0;
      end
    end else if (as) begin
      m_idx = int'(ai);
      got.delete();
    end else if (dv) begin
      got.push_back(d);
      if (got.size() == 3) begin
        m_addr = 8'(m_idx);
        m_rgb  = {got[0], got[1], got[2]};
        got.delete();
        pend = 1'b1;
      end
    end
    @(negedge clk_pix);
  endtask

  task automatic put(input logic [7:0] d);
    bit a;
    cyc(1'b0, 8'h00, 1'b1, d, 1'b1, a);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, a);
  endtask

  task automatic set_addr(input logic [7:0] ai);
    bit a;
    cyc(1'b1, ai, 1'b0, 8'h00, 1'b1, a);
  endtask

  initial begin
    bit a;
    logic [7:0] cur;
    rst_n = 1'b0; addr_set = 1'b0; addr_in = 8'h00; data_valid = 1'b0; data = 8'h00; vblank = 1'b0;
    model_reset();
    dut_wr = 0;
    repeat (2) @(negedge clk_pix);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_index", 32'(index), 32'd0);
    chk("rst_wr_rgb", 32'(wr_rgb), 32'd0);
    rst_n = 1'b1;
    @(negedge clk_pix);

    // 1: first triple from reset
    ready_low = 0;
    put(8'h12); put(8'h34); put(8'h56); idle(2);
    chk("t1_writes", 32'(dut_wr), 32'd1);
    chk("t1_ready_low", 32'(ready_low), 32'd1);
    chk("t1_addr", 32'(wr_addr), 32'h00);
    chk("t1_rgb", 32'(wr_rgb), 32'h123456);
    chk("t1_index", 32'(index), 32'h01);

    // 2: wrap from 0xFF
    dut_wr = 0;
    set_addr(8'hFF);
    put(8'hA1); put(8'hA2); put(8'hA3);
    idle(1);
    chk("t2_addr0", 32'(wr_addr), 32'hFF);
    put(8'hB1); put(8'hB2); put(8'hB3); idle(1);
    chk("t2_addr1", 32'(wr_addr), 32'h00);
    chk("t2_writes", 32'(dut_wr), 32'd2);
    chk("t2_index", 32'(index), 32'h01);

    // 3: addr_set drops partial R/G
    dut_wr = 0;
    put(8'hAA); put(8'hBB);
    cyc(1'b1, 8'h10, 1'b1, 8'hCC, 1'b1, a);
    chk("t3_no_accept", 32'(a), 32'd0);
    put(8'h01); put(8'h02); put(8'h03); idle(1);
    chk("t3_writes", 32'(dut_wr), 32'd1);
    chk("t3_addr", 32'(wr_addr), 32'h10);
    chk("t3_rgb", 32'(wr_rgb), 32'h010203);

    // 4: gaps in data_valid
    dut_wr = 0;
    cyc(1'b0, 8'h00, 1'b1, 8'h80, 1'b0, a);
    cyc(1'b0, 8'h00, 1'b0, 8'h40, 1'b0, a);
    cyc(1'b0, 8'h00, 1'b0, 8'h40, 1'b1, a);
    cyc(1'b0, 8'h00, 1'b1, 8'h40, 1'b0, a);
    cyc(1'b0, 8'h00, 1'b0, 8'h20, 1'b0, a);
`ifndef PALETTE_VBLANK_WR_EN
    chk("t4_no_early_write", 32'(dut_wr), 32'd0);
`endif
    cyc(1'b0, 8'h00, 1'b1, 8'h20, 1'b1, a);
    idle(2);
    chk("t4_writes", 32'(dut_wr), 32'd1);
    chk("t4_rgb", 32'(wr_rgb), 32'h804020);

    // 5: asynchronous reset between G and B
    dut_wr = 0;
    put(8'h77); put(8'h66);
    data_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_index", 32'(index), 32'd0);
    chk("t5_async_wr_en", 32'(wr_en), 32'd0);
    @(negedge clk_pix);
    rst_n = 1'b1;
    model_reset();
    idle(2);
    put(8'h01); put(8'h02); put(8'h03); idle(1);
    chk("t5_writes", 32'(dut_wr), 32'd1);
    chk("t5_addr", 32'(wr_addr), 32'h00);

`ifdef PALETTE_VBLANK_WR_EN
    // 6: commit held until vblank
    dut_wr = 0;
    cyc(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, a);
    cyc(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, a);
    cyc(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, a);
    for (int i = 0; i < 20; i++) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, a);
    chk("t6_stalled", 32'(dut_wr), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, a);
    chk("t6_writes", 32'(dut_wr), 32'd1);
    chk("t6_rgb", 32'(wr_rgb), 32'hFF00FF);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, a);
`endif

    // Random traffic: host holds a byte until it is accepted, occasionally reloads the index.
    cur = 8'($urandom);
    for (int i = 0; i < 400; i++) begin
      logic as;
      as = ($urandom_range(0, 19) == 0) && !pend;
      cyc(as, 8'($urandom), 1'($urandom_range(0, 3) != 0), cur, 1'($urandom_range(0, 2) != 0), a);
      if (a) cur = 8'($urandom);
    end
    idle(30);
    chk("rand_drained", 32'(pend), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
